serial_shift_unit: RTL and testbench
====================================

// Module: serial_shift_unit
// PURPOSE
//  Multi-cycle shifter at the consumer end of the sh_op interface driven by shift_control.
//  Latches an operand, sh_op and shift amount on start and shifts one bit position per clock.
//  Reports the result with a one-cycle done pulse.
//  Sits in the datapath beside the ALU; result feeds the register-file write-back mux.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  SHAMT_W  4   shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk       in   1        system clock, rising edge
//  rst       in   1        asynchronous, active-high reset
//  start     in   1        request; sampled on rising clk edge
//  sh_op     in   2        00 pass, 01 SLL, 10 SRL, 11 SRA
//  operand   in   WIDTH    value to shift
//  shamt     in   SHAMT_W  number of bit positions (0..2^SHAMT_W-1)
//  busy      out  1        high while in SHIFT state
//  done      out  1        one-cycle pulse; result/carry_out valid
//  result    out  WIDTH    shifted value, held until next accepted start
//  carry_out out  1        last bit shifted out; 0 if no shift performed
// BEHAVIOUR
//  Clocking: one clock (clk); rst is asynchronous and active-high.
//  Reset: state=IDLE, busy=0, done=0, result=0, carry_out=0, internal counter=0. Takes effect immediately.
//  All outputs are registered.
//  FSM: IDLE, SHIFT, DONE.
//   IDLE: start=1 -> latch operand into result, latch sh_op and shamt into count, clear carry_out.
//     Then go to SHIFT if sh_op!=00 and shamt!=0; otherwise go to DONE.
//   SHIFT: each edge performs one 1-bit shift and decrements count.
//     When count reaches 0 on that edge -> DONE.
//     start is ignored; operand, sh_op and shamt inputs are don't-care.
//   DONE: done=1 for exactly one cycle, then IDLE.
//     start=1 in DONE is accepted exactly as in IDLE, enabling back-to-back operations.
//  Shift step (W=WIDTH):
//   SLL: result <= {result[W-2:0],1'b0}; carry_out <= result[W-1]
//   SRL: result <= {1'b0,result[W-1:1]}; carry_out <= result[0]
//   SRA: result <= {result[W-1],result[W-1:1]}; carry_out <= result[0]
//  Latency: start high in cycle 0 -> done high in cycle N+1, where N = shamt for a real shift.
//   N = 0 for sh_op=00 or shamt=0; in that case result=operand and carry_out=0.
//  busy: high in cycles 1..N; low in IDLE and DONE.
//  result/carry_out are stable from done until the next accepted start.
//  Reset during SHIFT: the operation is abandoned and no done pulse is issued.
//   The next start after reset release behaves normally.
//  sh_op=00 with nonzero shamt: pass-through, done in cycle 1.
//  Maximum shamt (2^SHAMT_W-1): shifts that many positions; no saturation or wrap.
// TESTING
//  1 SLL: operand=16'h0001, shamt=4 -> done in cycle 5, result=16'h0010, carry_out=0; busy high cycles 1-4.
//  2 SRA: operand=16'h8000, shamt=15 -> done in cycle 16, result=16'hFFFF, carry_out=0.
//    SRL with same inputs -> result=16'h0001.
//  3 SRL: operand=16'h8001, shamt=1 -> done in cycle 2, result=16'h4000, carry_out=1.
//    SLL: operand=16'h8001, shamt=1 -> result=16'h0002, carry_out=1.
//  4 Zero shift: operand=16'hA5A5 with sh_op=00, shamt=7, and again with sh_op=01, shamt=0.
//    -> done in cycle 1, result=16'hA5A5, carry_out=0, busy never high.
//  5 Protocol: during SLL shamt=8, pulse start with operand=16'hFFFF in cycle 3 -> ignored.
//    Original result is produced.
//    Then assert start in the DONE cycle -> second op accepted, its done in the expected cycle.
//  6 Reset: assert rst asynchronously mid-cycle 3 of an 8-cycle shift.
//    -> busy/done/result/carry_out = 0 immediately, no done pulse.
//    A fresh SLL 16'h0003 by 2 then yields 16'h000C.

Source files
------------

// File: rtl/serial_shift_unit.sv
// Multi-cycle shifter: latches operand/sh_op/shamt on start, shifts one bit per clock,
// and reports result/carry_out with a one-cycle done pulse.
module serial_shift_unit #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         sh_op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRL  = 2'b10,
    OP_SRA  = 2'b11
  } op_t;

  state_t             state, state_nxt;
  op_t                op_q;
  logic [SHAMT_W-1:0] count;
  logic               accept;
  logic               real_shift;
  logic               busy_nxt, done_nxt;

  // A new request is taken in IDLE and also in DONE so operations can run back to back.
  assign accept     = start && (state != SHIFT);
  assign real_shift = (op_t'(sh_op) != OP_PASS) && (shamt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)          state_nxt = real_shift ? SHIFT : DONE;
        else if (state == DONE) state_nxt = IDLE;
      end
      SHIFT: begin
        if (count == SHAMT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so both leave the block as flops.
  always_comb begin
    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      count     <= '0;
      op_q      <= OP_PASS;
    end else if (accept) begin
      result    <= operand;
      carry_out <= 1'b0;
      count     <= shamt;
      op_q      <= op_t'(sh_op);
    end else if (state == SHIFT) begin
      count <= count - SHAMT_W'(1);
      case (op_q)
        OP_SLL: begin
          result    <= {result[WIDTH-2:0], 1'b0};
          carry_out <= result[WIDTH-1];
        end
        OP_SRL: begin
          result    <= {1'b0, result[WIDTH-1:1]};
          carry_out <= result[0];
        end
        OP_SRA: begin
          result    <= {result[WIDTH-1], result[WIDTH-1:1]};
          carry_out <= result[0];
        end
        default: begin
          result    <= result;
          carry_out <= carry_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: driver pushes expected responses, a monitor
// checks done timing, result, carry_out, busy and result stability.
module tb_serial_shift_unit;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   sh_op = 2'b00;
  logic [W-1:0] operand = '0;
  logic [S-1:0] shamt = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] result;

  serial_shift_unit #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk(clk), .rst(rst), .start(start), .sh_op(sh_op), .operand(operand),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           acc;   // edge index at which start is taken
    int           dn;    // cycle index in which done must be high
    bit           shifting;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] last_res = '0;
  logic         last_c = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: whole shift computed in one step from the arithmetic definition.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input int s,
                       output logic [W-1:0] r, output logic c);
    logic signed [W-1:0] sa;
    sa = a;
    if (op == 2'b00 || s == 0) begin
      r = a; c = 1'b0;
    end else if (op == 2'b01) begin
      r = a << s; c = a[W-s];
    end else if (op == 2'b10) begin
      r = a >> s; c = a[s-1];
    end else begin
      r = sa >>> s; c = a[s-1];
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.dn));
          check("result", 32'(result), 32'(e.res));
          check("carry_out", 32'(carry_out), 32'(e.c));
          last_res = e.res;
          last_c   = e.c;
        end
      end else if (sb.size() != 0 && cyc > sb[0].dn) begin
        check("missing_done", 32'(done), 32'd1);
        void'(sb.pop_front());
      end
      if (sb.size() != 0)
        check("busy", 32'(busy),
              32'(sb[0].shifting && cyc >= sb[0].acc && cyc < sb[0].dn));
      else begin
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(last_res));
        check("carry_hold", 32'(carry_out), 32'(last_c));
      end
    end
  end

  // Drives one request right after a rising edge and records its expected response.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input int s, output int dn);
    exp_t e;
    logic [W-1:0] r;
    logic c;
    model(op, a, s, r, c);
    start = 1'b1; sh_op = op; operand = a; shamt = S'(s);
    e.res = r; e.c = c; e.acc = cyc + 1;
    e.shifting = (op != 2'b00 && s != 0);
    e.dn = e.acc + (e.shifting ? s : 0);
    dn = e.dn;
    sb.push_back(e);
    @(posedge clk); #2;
    start = 1'b0; sh_op = 2'($urandom); operand = W'($urandom); shamt = S'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_until(input int t);
    int k;
    k = 0;
    while (cyc < t && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input int s);
    int dn;
    wait_idle();
    issue(op, a, s, dn);
    wait_idle();
  endtask

  initial begin
    int dn, dn2, acc;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    run_op(2'b01, 16'h0001, 4);
    run_op(2'b11, 16'h8000, 15);
    run_op(2'b10, 16'h8000, 15);
    run_op(2'b10, 16'h8001, 1);
    run_op(2'b01, 16'h8001, 1);
    run_op(2'b00, 16'hA5A5, 7);
    run_op(2'b01, 16'hA5A5, 0);

    // Start during SHIFT is ignored; start in the DONE cycle is accepted.
    wait_idle();
    acc = cyc + 1;
    issue(2'b01, 16'h1234, 8, dn);
    wait_until(acc + 2);
    start = 1'b1; sh_op = 2'b10; operand = 16'hFFFF; shamt = 4'd3;
    @(posedge clk); #2;
    start = 1'b0;
    wait_until(dn);
    issue(2'b11, 16'h9001, 3, dn2);
    wait_idle();

    // Asynchronous reset in the middle of a shift.
    acc = cyc + 1;
    issue(2'b01, 16'h00FF, 8, dn);
    wait_until(acc + 2);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_carry", 32'(carry_out), 32'd0);
    sb.delete();
    last_res = '0; last_c = 1'b0;
    @(posedge clk); #2;
    check("arst_hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    run_op(2'b01, 16'h0003, 2);

    // Randomised traffic with gaps and back-to-back requests.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [W-1:0] a;
      int s;
      op = 2'($urandom);
      a  = W'($urandom);
      s  = $urandom_range(0, 15);
      if (sb.size() != 0 && $urandom_range(0, 1) == 1) begin
        wait_until(sb[sb.size()-1].dn);
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
      end
      issue(op, a, s, dn);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
